// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared CPU defines for the fetch unit (FSM encodings, NOP word).
package ifu_fetch_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } fetch_state_t;
  localparam logic [31:0] INST_NOP = 32'h00000013;
endpackage

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with flush-safe response dropping.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h80000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            pc_ready_o,
  input  logic            jump_en_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            inst_valid_o,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] inst_addr_o,
  input  logic            inst_ready_i,
  output logic            misalign_o
);
  fetch_state_t    r_state, w_next;
  logic            r_drop, w_drop;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic            w_accept, w_misaligned_pc, w_take_data;
  assign w_accept        = (r_state == S_IDLE) && pc_valid_i && !jump_en_i;
  assign w_misaligned_pc = |pc_i[1:0];
  assign w_take_data     = (r_state == S_WAIT) && imem_rvalid_i && !r_drop && !jump_en_i;
  always_comb begin
    w_next       = r_state;
    w_drop       = r_drop;
    pc_ready_o   = 1'b0;
    imem_req_o   = 1'b0;
    inst_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        pc_ready_o = !jump_en_i;
        w_drop     = 1'b0;
        w_next     = w_accept ? (w_misaligned_pc ? S_OUT : S_REQ) : S_IDLE;
      end
      S_REQ: begin
        imem_req_o = 1'b1;
        w_drop     = r_drop | jump_en_i;
        w_next     = imem_gnt_i ? S_WAIT : S_REQ;
      end
      S_WAIT: begin
        // a flush while waiting still owes the memory a response; swallow it
        w_drop = imem_rvalid_i ? 1'b0 : (r_drop | jump_en_i);
        w_next = imem_rvalid_i ? (w_take_data ? S_OUT : S_IDLE) : S_WAIT;
      end
      S_OUT: begin
        inst_valid_o = 1'b1;
        w_next       = (jump_en_i || inst_ready_i) ? S_IDLE : S_OUT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
      r_pc    <= RESET_PC;
      r_inst  <= INST_NOP;
    end else begin
      r_state <= w_next;
      r_drop  <= w_drop;
      if (w_accept) r_pc <= pc_i;
      if (w_accept && w_misaligned_pc) r_inst <= INST_NOP;
      else if (w_take_data) r_inst <= imem_rdata_i;
    end
  end
  assign imem_addr_o = r_pc;
  assign inst_addr_o = r_pc;
  assign inst_o      = r_inst;
  assign misalign_o  = inst_valid_o && |r_pc[1:0];
endmodule
